// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] INSTR_STEP = 32'd4;
  localparam logic [XLEN-1:0] HALT_WORD  = 32'h0;
  localparam logic [XLEN-1:0] ALIGN_MASK = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush clears valid and takes priority over load.
module if_id_reg
  import fetch_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            flush,
  input  logic [XLEN-1:0] instr_d,
  input  logic [XLEN-1:0] pc_d,
  output logic            valid,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] pc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      instr <= '0;
      pc    <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      instr <= instr_d;
      pc    <= pc_d;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, BOOT/RUN/HALT control and IF/ID register.
// Define FETCH_MISALIGN_CHECK_EN to trap misaligned redirects into HALT.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rd,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  input  logic            id_ready,
  output logic            id_valid,
  output logic [XLEN-1:0] id_instr,
  output logic [XLEN-1:0] id_pc,
  output logic            halted
`ifdef FETCH_MISALIGN_CHECK_EN
  ,
  output logic            misalign_err
`endif
);

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            load, flush;
  logic            halted_q;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic            misalign_q, misalign_d;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= BOOT;
      pc_q     <= RESET_PC;
      halted_q <= 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
      misalign_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      halted_q <= (state_d == HALT);
`ifdef FETCH_MISALIGN_CHECK_EN
      misalign_q <= misalign_d;
`endif
    end
  end

  // Next state, PC and IF/ID control; a redirect overrides everything else.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    load    = 1'b0;
    flush   = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
    misalign_d = misalign_q;
`endif
    case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (!id_valid || id_ready) begin
          if (imem_rd == HALT_WORD) begin
            flush   = 1'b1;
            state_d = HALT;
          end else begin
            load = 1'b1;
            pc_d = pc_q + INSTR_STEP;
          end
        end
      end
      HALT: begin
        if (id_ready) flush = 1'b1;
      end
      default: state_d = BOOT;
    endcase

    if (redirect_valid) begin
      load  = 1'b0;
      flush = 1'b1;
`ifdef FETCH_MISALIGN_CHECK_EN
      if (redirect_target[1:0] != 2'b00) begin
        pc_d       = pc_q;
        state_d    = HALT;
        misalign_d = 1'b1;
      end else begin
        pc_d       = redirect_target;
        state_d    = RUN;
        misalign_d = 1'b0;
      end
`else
      pc_d    = redirect_target & ALIGN_MASK;
      state_d = RUN;
`endif
    end
  end

  if_id_reg u_if_id_reg (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load),
    .flush   (flush),
    .instr_d (imem_rd),
    .pc_d    (pc_q),
    .valid   (id_valid),
    .instr   (id_instr),
    .pc      (id_pc)
  );

  assign imem_addr = pc_q;
  assign halted    = halted_q;
`ifdef FETCH_MISALIGN_CHECK_EN
  assign misalign_err = misalign_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit with a combinational instruction memory model.
`timescale 1ns/1ps
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_rd;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        id_ready;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic        halted;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic        misalign_err;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Program 0x00-0x18, halt word at 0x1C, non-zero filler elsewhere.
  function automatic logic [31:0] imem_word(input logic [31:0] addr);
    case (addr)
      32'h00: return 32'h0F30_0093;
      32'h04: return 32'h0090_0113;
      32'h08: return 32'h0020_8193;
      32'h0C: return 32'h0031_0233;
      32'h10: return 32'h0041_82B3;
      32'h14: return 32'h0052_0333;
      32'h18: return 32'h0062_83B3;
      32'h1C: return 32'h0000_0000;
      default: return 32'h1000_0000 | addr;
    endcase
  endfunction

  assign imem_rd = imem_word(imem_addr);

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .imem_addr       (imem_addr),
    .imem_rd         (imem_rd),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .id_ready        (id_ready),
    .id_valid        (id_valid),
    .id_instr        (id_instr),
    .id_pc           (id_pc),
    .halted          (halted)
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    .misalign_err    (misalign_err)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one cycle; sample on the falling edge.
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst_n           = 1'b0;
    id_ready        = 1'b1;
    redirect_valid  = 1'b0;
    redirect_target = 32'h0;
    @(negedge clk);
    @(negedge clk);
    check("rst_valid",  32'(id_valid), 32'd0);
    check("rst_addr",   imem_addr, 32'h0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_pc",     id_pc, 32'h0);
    check("rst_instr",  id_instr, 32'h0);

    // Boot cycle, then straight-line fetch
    rst_n = 1'b1;
    cyc();
    check("boot_valid", 32'(id_valid), 32'd0);
    check("boot_addr",  imem_addr, 32'h0);
    cyc();
    check("f0_valid", 32'(id_valid), 32'd1);
    check("f0_pc",    id_pc, 32'h00);
    check("f0_instr", id_instr, 32'h0F30_0093);
    cyc();
    check("f1_pc",    id_pc, 32'h04);
    check("f1_instr", id_instr, 32'h0090_0113);
    cyc();
    check("f2_pc", id_pc, 32'h08);

    // Three-cycle stall holds everything
    id_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("stall_pc",    id_pc, 32'h08);
      check("stall_instr", id_instr, 32'h0020_8193);
      check("stall_addr",  imem_addr, 32'h0C);
      check("stall_valid", 32'(id_valid), 32'd1);
    end
    id_ready = 1'b1;
    cyc();
    check("unstall_pc", id_pc, 32'h0C);

    // Redirect during a stall flushes and wins
    id_ready        = 1'b0;
    redirect_valid  = 1'b1;
    redirect_target = 32'h14;
    cyc();
    check("redir_valid", 32'(id_valid), 32'd0);
    check("redir_addr",  imem_addr, 32'h14);
    redirect_valid = 1'b0;
    id_ready       = 1'b1;
    cyc();
    check("redir_pc",    id_pc, 32'h14);
    check("redir_instr", id_instr, 32'h0052_0333);
    cyc();
    check("f18_pc", id_pc, 32'h18);

    // Halt word at 0x1C
    cyc();
    check("halt_flag",  32'(halted), 32'd1);
    check("halt_addr",  imem_addr, 32'h1C);
    check("halt_valid", 32'(id_valid), 32'd0);
    cyc();
    check("halt_hold_flag", 32'(halted), 32'd1);
    check("halt_hold_addr", imem_addr, 32'h1C);

    // Redirect out of HALT
    redirect_valid  = 1'b1;
    redirect_target = 32'h00;
    cyc();
    check("resume_halted", 32'(halted), 32'd0);
    check("resume_addr",   imem_addr, 32'h00);
    redirect_valid = 1'b0;
    cyc();
    check("resume_pc",    id_pc, 32'h00);
    check("resume_instr", id_instr, 32'h0F30_0093);

    // Misaligned redirect to 0x06 (PC currently 0x04)
    redirect_valid  = 1'b1;
    redirect_target = 32'h06;
    cyc();
    redirect_valid = 1'b0;
    check("mis_valid", 32'(id_valid), 32'd0);
`ifdef FETCH_MISALIGN_CHECK_EN
    check("mis_err",    32'(misalign_err), 32'd1);
    check("mis_halted", 32'(halted), 32'd1);
    check("mis_addr",   imem_addr, 32'h04);
    cyc();
    check("mis_hold_addr", imem_addr, 32'h04);
    redirect_valid  = 1'b1;
    redirect_target = 32'h08;
    cyc();
    redirect_valid = 1'b0;
    check("mis_clr_err",    32'(misalign_err), 32'd0);
    check("mis_clr_halted", 32'(halted), 32'd0);
    check("mis_clr_addr",   imem_addr, 32'h08);
    cyc();
    check("mis_clr_pc", id_pc, 32'h08);
`else
    check("mis_addr", imem_addr, 32'h04);
    cyc();
    check("mis_pc",    id_pc, 32'h04);
    check("mis_instr", id_instr, 32'h0090_0113);
`endif

    // PC wrap at the top of the address space
    redirect_valid  = 1'b1;
    redirect_target = 32'hFFFF_FFFC;
    cyc();
    redirect_valid = 1'b0;
    check("wrap_start", imem_addr, 32'hFFFF_FFFC);
    cyc();
    check("wrap_addr",  imem_addr, 32'h0000_0000);
    check("wrap_pc",    id_pc, 32'hFFFF_FFFC);
    check("wrap_instr", id_instr, imem_word(32'hFFFF_FFFC));

    // Reach HALT again, then reset asynchronously
    redirect_valid  = 1'b1;
    redirect_target = 32'h18;
    cyc();
    redirect_valid = 1'b0;
    cyc();
    cyc();
    check("halt2_flag", 32'(halted), 32'd1);
    rst_n = 1'b0;
    #1;
    check("arst_halted", 32'(halted), 32'd0);
    check("arst_addr",   imem_addr, 32'h0);
    check("arst_valid",  32'(id_valid), 32'd0);
    check("arst_pc",     id_pc, 32'h0);
    check("arst_instr",  id_instr, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    check("reboot_valid", 32'(id_valid), 32'd0);
    cyc();
    check("reboot_pc",    id_pc, 32'h00);
    check("reboot_instr", id_instr, 32'h0F30_0093);
    check("reboot_valid1", 32'(id_valid), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port imem_addr, output, 32: fetch address to the combinational instruction memory; equals pc_q.
REQ-005 SHALL have port imem_rd, input, 32: instruction word returned for imem_addr in the same cycle.
REQ-006 SHALL have port redirect_valid, input, 1: branch/jump redirect request.
REQ-007 SHALL have port redirect_target, input, 32: new PC, used when redirect_valid=1.
REQ-008 SHALL have port id_ready, input, 1: decode stage accepts id_instr this cycle.
REQ-009 SHALL have port id_valid, output, 1: id_instr/id_pc hold a valid fetched instruction.
REQ-010 SHALL have port id_instr, output, 32: registered instruction word.
REQ-011 SHALL have port id_pc, output, 32: address of id_instr.
REQ-012 SHALL have port halted, output, 1: FSM is in HALT.
REQ-013 SHALL have port misalign_err, output, 1: sticky misaligned-redirect flag; present only with FETCH_MISALIGN_CHECK_EN.

Function
REQ-014 SHALL implement FSM states BOOT, RUN and HALT; state after reset SHALL be BOOT.
REQ-015 In BOOT, SHALL perform no fetch and keep id_valid=0; next state SHALL be RUN, or RUN at redirect_target if redirect_valid=1.
REQ-016 In RUN, load SHALL be (!id_valid || id_ready); on load SHALL set id_instr<=imem_rd, id_pc<=pc_q, id_valid<=1, pc_q<=pc_q+4.
REQ-017 In RUN with id_valid=1 and id_ready=0 (stall), SHALL hold pc_q, id_instr, id_pc and id_valid unchanged.
REQ-018 In RUN, if load and imem_rd==32'h0, SHALL NOT forward the word: id_valid<=0, pc_q held, next state HALT.
REQ-019 In HALT, SHALL perform no loads, hold pc_q, drive halted=1, and clear id_valid once the held instruction is accepted (id_ready=1).
REQ-020 redirect_valid=1 in any state SHALL win over stall, load and halt detection: pc_q<=redirect_target, id_valid<=0 (flush), next state RUN.
REQ-021 Fetch latency SHALL be one cycle: the instruction at pc_q appears on id_instr the cycle after load.
REQ-022 PC arithmetic SHALL be modulo 2^32: 32'hFFFF_FFFC+4 SHALL wrap to 32'h0.
REQ-023 Without the macro, redirect_target[1:0] SHALL be forced to 2'b00 before loading pc_q.

Reset
REQ-024 On rst_n=0, SHALL immediately set pc_q=RESET_PC, id_valid=0, id_instr=0, id_pc=0, halted=0, misalign_err=0 and state=BOOT, independent of clk.
REQ-025 Reset asserted mid-stall or in HALT SHALL discard all held state; the first fetch after release SHALL be at RESET_PC.

Configuration
REQ-026 Macro FETCH_MISALIGN_CHECK_EN defined: redirect with target[1:0]!=0 SHALL NOT load pc_q, SHALL flush id_valid, set misalign_err=1 and enter HALT; an aligned redirect SHALL clear misalign_err and resume RUN.
REQ-027 Macro undefined: port misalign_err and its logic SHALL be absent, and REQ-023 SHALL apply.

Structure
REQ-028 Shared package fetch_pkg SHALL hold the FSM state enum, the instruction step constant 32'd4 and the halt-word constant 32'h0.
REQ-029 The IF/ID register (valid/instr/pc with load and flush) SHALL be the sub-module if_id_reg; PC and FSM logic SHALL stay in fetch_unit.

Verification
REQ-030 Reset release with id_ready=1 and imem returning 0x0F300093 at 0x00 -> BOOT for 1 cycle, then id_instr=0x0F300093, id_pc=0x00, id_valid=1; next cycle id_pc=0x04, id_instr=0x00900113.
REQ-031 id_ready=0 for 3 cycles with id_pc=0x08 -> id_pc, id_instr and imem_addr=0x0C held; id_ready=1 -> id_pc=0x0C next cycle.
REQ-032 redirect_valid=1, target=0x14, during a stall -> next cycle id_valid=0 and imem_addr=0x14; the following cycle id_pc=0x14.
REQ-033 Straight-line program 0x00-0x18 with imem returning 0 at 0x1C -> halted=1, imem_addr held at 0x1C, id_valid=0 after 0x18 is accepted; redirect to 0x00 -> RUN.
REQ-034 With FETCH_MISALIGN_CHECK_EN defined, redirect to 0x06 -> misalign_err=1, halted=1, pc held; redirect to 0x08 -> misalign_err=0, fetch at 0x08; with it undefined, 0x06 -> fetch at 0x04.
REQ-035 PC at 0xFFFF_FFFC with a non-zero word -> next imem_addr=0x0000_0000; rst_n pulsed low in HALT -> outputs reset immediately and fetch restarts at RESET_PC.
